// File: rtl/t03_pc_ctrl_if.sv
// Decoder/branch-unit to PC-controller bundle: redirect requests in, PC/EPC/status out.
// Latency: pure wiring, no storage.
// Backpressure: fetch_ack and en gate the controller; T03_PC_COMPRESSED_EN adds instr_compressed.
interface t03_pc_ctrl_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 en;
  logic                 fetch_ack;
  logic [XLEN-1:0]      imm;
  logic                 branch_taken;
  logic                 jal;
  logic                 jalr;
  logic [XLEN-1:0]      rs1_value;
  logic                 auipc;
  logic                 trap_req;
  logic [XLEN-1:0]      trap_vector;
  logic                 mret;
`ifdef T03_PC_COMPRESSED_EN
  logic                 instr_compressed;
`endif
  logic [XLEN-1:0]      pc_out;
  logic [XLEN-1:0]      pc_add_out;
  logic [XLEN-1:0]      epc_out;
  logic                 fault;
  logic [CNT_WIDTH-1:0] retire_count;

  // Decoder / branch unit side
  modport master (
    output en, fetch_ack, imm, branch_taken, jal, jalr, rs1_value, auipc,
           trap_req, trap_vector, mret,
`ifdef T03_PC_COMPRESSED_EN
           instr_compressed,
`endif
    input  pc_out, pc_add_out, epc_out, fault, retire_count
  );

  // PC controller side
  modport slave (
    input  en, fetch_ack, imm, branch_taken, jal, jalr, rs1_value, auipc,
           trap_req, trap_vector, mret,
`ifdef T03_PC_COMPRESSED_EN
           instr_compressed,
`endif
    output pc_out, pc_add_out, epc_out, fault, retire_count
  );
endinterface

// File: rtl/t03_pc_ctrl.sv
// Program-counter controller: sequential/branch/JAL/JALR/trap/MRET next-PC with misaligned-target fault FSM.
// Latency: pc/epc/fault/retire_count registered (1 cycle); pc_add_out combinational from current pc.
// Backpressure: advances only when en & fetch_ack; trap/mret need only en. Macro T03_PC_COMPRESSED_EN enables 2-byte steps.
module t03_pc_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_WIDTH    = 32
) (
  input logic         clock,
  input logic         reset,
  t03_pc_ctrl_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      pc_nxt;
  logic [XLEN-1:0]      epc;
  logic [XLEN-1:0]      epc_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  logic [XLEN-1:0]      step;
  logic [XLEN-1:0]      target;
  logic                 redirect;
  logic                 misaligned;
  logic                 advance;

  assign advance = bus.en & bus.fetch_ack;

  // Sequential step size; 2 bytes only for compressed instructions
  always_comb begin
    step = XLEN'(4);
`ifdef T03_PC_COMPRESSED_EN
    if (bus.instr_compressed) step = XLEN'(2);
`endif
  end

  // Candidate target (jalr > jal/branch > sequential) and its alignment check
  always_comb begin
    redirect = bus.jalr | bus.jal | bus.branch_taken;
    if (bus.jalr)
      target = (bus.rs1_value + bus.imm) & ~XLEN'(1);
    else if (bus.jal || bus.branch_taken)
      target = pc + bus.imm;
    else
      target = pc + step;
`ifdef T03_PC_COMPRESSED_EN
    misaligned = redirect & target[0];
`else
    misaligned = redirect & (target[1:0] != 2'b00);
`endif
  end

  // Next-state logic: trap beats mret beats fault detection beats normal advance
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    epc_nxt   = epc;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (bus.en && bus.trap_req) begin
          pc_nxt  = bus.trap_vector;
          epc_nxt = pc;
        end else if (bus.en && bus.mret) begin
          pc_nxt = epc;
        end else if (advance && misaligned) begin
          state_nxt = FAULT;
          epc_nxt   = pc;
        end else if (advance) begin
          pc_nxt  = target;
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      FAULT: begin
        // Only a trap leaves FAULT; epc keeps the faulting PC
        if (bus.en && bus.trap_req) begin
          pc_nxt    = bus.trap_vector;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_VECTOR;
      epc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      epc   <= epc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign bus.pc_out       = pc;
  assign bus.pc_add_out   = bus.auipc ? (pc + bus.imm) : (pc + step);
  assign bus.epc_out      = epc;
  assign bus.fault        = (state == FAULT);
  assign bus.retire_count = cnt;

endmodule
